regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 integer register file among three writeback requesters: ALU/CSR writeback, load/store unit, and debug module. Uses round-robin arbitration with valid/ready handshakes and drives a registered write port into the regfile. A scoreboard of pending load destinations gives the decode stage a read-hazard indication. Sits between the execute/memory stages and the regfile.

Parameters:
NREQ, 3, number of requesters; fixed at 3 (0=ALU, 1=LSU, 2=debug)
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  3  per-requester write request
req_rd  input  3x5  per-requester destination register
req_data  input  3x32  per-requester write data
req_ready  output  3  per-requester grant (combinational, one-hot or zero)
issue_valid  input  1  load issued by LSU; reserve destination
issue_rd  input  5  destination of issued load
issue_ready  output  1  reservation accepted
flush  input  1  clear all reservations (trap/redirect)
ra  input  5  decode read address A
rb  input  5  decode read address B
ra_busy  output  1  ra has pending or in-flight write
rb_busy  output  1  rb has pending or in-flight write
rf_wr  output  1  regfile write enable (registered)
rf_rd  output  5  regfile write address (registered)
rf_rd_d  output  32  regfile write data (registered)

Behaviour:
- Reset (rst=1 at posedge): rf_wr=0, rf_rd=0, rf_rd_d=0, all pend bits=0, last_grant=2. Outputs req_ready=0 and issue_ready=0 while rst=1.
- Handshake: a requester holds req_valid, req_rd and req_data stable until req_ready=1. Transfer occurs in the cycle where valid&ready=1. Deasserting valid before the grant is legal; the request is then dropped.
- Arbitration: combinational round-robin. Search order starts at (last_grant+1) mod 3 and wraps. The first valid requester found gets req_ready. At most one grant per cycle. last_grant updates to the winner on the clock edge of a transfer; it holds when there is no transfer.
- Fairness: with all three requesters continuously valid, grants rotate 0,1,2,0,... Any requester is granted within 3 cycles of asserting valid.
- Write port: on a transfer in cycle N, rf_wr=1, rf_rd=req_rd and rf_rd_d=req_data are valid in cycle N+1, and the regfile updates at the end of N+1. With no transfer, rf_wr=0; rf_rd and rf_rd_d hold their last values.
- x0: a request to rd=0 is granted normally, but rf_wr stays 0 in N+1.
- Scoreboard: pend[31:1]; pend[0] is hardwired to 0.
- issue_ready = !rst & !flush & !(issue_rd!=0 & pend[issue_rd]).
  - When issue_valid&issue_ready and issue_rd!=0, set pend[issue_rd].
  - issue_rd=0 is accepted with no effect.
- Clear: an LSU (requester 1) transfer to rd clears pend[rd] at that edge. ALU and debug transfers do not touch pend.
- Same-cycle set and clear of the same register: set wins.
- flush=1 clears all pend bits at the edge. flush has priority over set and clear. Grants and the write port are unaffected.
- ra_busy = pend[ra] | (rf_wr & rf_rd==ra & ra!=0). rb_busy is the same with rb. Both are combinational, and ra=0 or rb=0 is never busy.
- Reset mid-operation: any pending grant is lost. rf_wr is 0 in the cycle after the reset edge, and requesters must re-present their requests.

Test Plan:
- Reset then idle: all outputs 0. Assert req_valid=3'b111 (rd=5/6/7, data=A/B/C) for 6 cycles -> grants 0,1,2,0,1,2. rf_wr=1 one cycle after each grant, with matching rd/data.
- Single requester: req_valid=3'b010, rd=9, data=0xDEADBEEF -> req_ready[1]=1 same cycle. Next cycle rf_wr=1, rf_rd=9, rf_rd_d=0xDEADBEEF. The cycle after, rf_wr=0.
- x0 write: ALU request rd=0, data=0x1234 -> req_ready[0]=1, rf_wr remains 0.
- Scoreboard:
  - issue rd=12 -> ra=12 gives ra_busy=1.
  - Second issue rd=12 -> issue_ready=0.
  - LSU transfer rd=12 -> ra_busy=1 in the next cycle (in-flight), 0 the cycle after.
- Same-cycle LSU writeback rd=4 with issue rd=4 -> pend[4] remains 1. flush with issue rd=8 -> issue_ready=0 and all pend bits 0 after the edge.
- Assert rst while ALU and LSU are both valid -> no rf_wr in the following cycle and last_grant=2. After release, ALU (0) is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by the three regfile writers.
//   req_valid : per-requester write request
//   req_rd    : per-requester destination register (packed, one entry per requester)
//   req_data  : per-requester write data (packed, one entry per requester)
//   req_ready : per-requester grant, one-hot or zero
// Modports: master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][AW-1:0]   req_rd;
    logic [NREQ-1:0][XLEN-1:0] req_data;
    logic [NREQ-1:0]           req_ready;

    modport master (output req_valid, output req_rd, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_rd, input  req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, with a
// pending-load scoreboard that flags read hazards to decode.
//   clk, rst      : core clock, synchronous active-high reset
//   wb            : writeback request bus (0=ALU, 1=LSU, 2=debug)
//   issue_valid/issue_rd/issue_ready : load destination reservation
//   flush         : drop all reservations
//   ra, rb        : decode read addresses; ra_busy/rb_busy hazard flags
//   rf_wr, rf_rd, rf_rd_d : registered regfile write port
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave wb,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                flush,
    input  logic [AW-1:0]       ra,
    input  logic [AW-1:0]       rb,
    output logic                ra_busy,
    output logic                rb_busy,
    output logic                rf_wr,
    output logic [AW-1:0]       rf_rd,
    output logic [XLEN-1:0]     rf_rd_d
);
    localparam int        GW  = $clog2(NREQ);
    localparam logic [GW-1:0] LSU = GW'(1);
    localparam int        NR  = 2 ** AW;

    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win;
    logic [GW-1:0]   cand;
    logic            xfer;
    logic [NREQ-1:0] ready;
    logic [NR-1:0]   pend;
    logic [NR-1:0]   pend_nxt;

    // Search starts just after the last winner and wraps, so every valid
    // requester is reached within NREQ grants.
    always_comb begin
        ready = '0;
        xfer  = 1'b0;
        win   = '0;
        cand  = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == GW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!xfer && wb.req_valid[cand]) begin
                xfer = 1'b1;
                win  = cand;
            end
        end
        if (rst) xfer = 1'b0;
        if (xfer) ready[win] = 1'b1;
    end

    assign wb.req_ready = ready;

    assign issue_ready = !rst && !flush && !(issue_rd != '0 && pend[issue_rd]);

    // Clear before set so a same-cycle reservation of the register the LSU
    // is retiring stays pending; flush overrides both.
    always_comb begin
        pend_nxt = pend;
        if (xfer && win == LSU)
            pend_nxt[wb.req_rd[win]] = 1'b0;
        if (issue_valid && issue_ready && issue_rd != '0)
            pend_nxt[issue_rd] = 1'b1;
        if (flush)
            pend_nxt = '0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr      <= 1'b0;
            rf_rd      <= '0;
            rf_rd_d    <= '0;
            pend       <= '0;
            last_grant <= GW'(NREQ - 1);
        end else begin
            // x0 writes are granted and retired but never reach the regfile.
            rf_wr <= xfer && (wb.req_rd[win] != '0);
            if (xfer) begin
                rf_rd      <= wb.req_rd[win];
                rf_rd_d    <= wb.req_data[win];
                last_grant <= win;
            end
            pend <= pend_nxt;
        end
    end

    // A write sitting on the port this cycle is still a hazard: the regfile
    // only takes it at the end of the cycle.
    assign ra_busy = pend[ra] | (rf_wr && rf_rd == ra && ra != '0);
    assign rb_busy = pend[rb] | (rf_wr && rf_rd == rb && rb != '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic [4:0]  ra, rb;
    logic        ra_busy, rb_busy;
    logic        rf_wr;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_d;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    regfile_wb_arbiter_if #(.NREQ(3), .XLEN(32), .AW(5)) wb ();

    regfile_wb_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .flush(flush), .ra(ra), .rb(rb), .ra_busy(ra_busy), .rb_busy(rb_busy),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_rd_d(rf_rd_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register state as plain values, evaluated at the
    // falling edge while inputs are stable, then advanced to the next edge.
    int          m_lg   = 2;
    bit [31:0]   m_pend = '0;
    bit          m_wr   = 0;
    bit [4:0]    m_rd   = '0;
    bit [31:0]   m_data = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            int        w;
            bit [2:0]  e_ready;
            bit        e_iss;
            bit        e_ra, e_rb;
            w = -1;
            if (!rst)
                for (int k = 1; k <= 3; k++)
                    if (w < 0 && wb.req_valid[(m_lg + k) % 3]) w = (m_lg + k) % 3;
            e_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
            e_iss   = !rst && !flush && !(issue_rd != 0 && m_pend[issue_rd]);
            e_ra    = (ra != 0) && (m_pend[ra] || (m_wr && m_rd == ra));
            e_rb    = (rb != 0) && (m_pend[rb] || (m_wr && m_rd == rb));
            chk("m_req_ready", 32'(wb.req_ready), 32'(e_ready));
            chk("m_issue_ready", 32'(issue_ready), 32'(e_iss));
            chk("m_ra_busy", 32'(ra_busy), 32'(e_ra));
            chk("m_rb_busy", 32'(rb_busy), 32'(e_rb));
            chk("m_rf_wr", 32'(rf_wr), 32'(m_wr));
            chk("m_rf_rd", 32'(rf_rd), 32'(m_rd));
            chk("m_rf_rd_d", rf_rd_d, m_data);
            if (rst) begin
                m_lg = 2; m_pend = '0; m_wr = 0; m_rd = '0; m_data = '0;
            end else begin
                m_wr = (w >= 0) && (wb.req_rd[w] != 0);
                if (w >= 0) begin
                    m_rd = wb.req_rd[w]; m_data = wb.req_data[w]; m_lg = w;
                    if (w == 1) m_pend[wb.req_rd[w]] = 1'b0;
                end
                if (issue_valid && e_iss && issue_rd != 0) m_pend[issue_rd] = 1'b1;
                if (flush) m_pend = '0;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask
    task automatic probe;
        @(negedge clk); #1;
    endtask

    initial begin
        bit [2:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst = 1; issue_valid = 0; issue_rd = '0; flush = 0; ra = '0; rb = '0;
        wb.req_valid = '0; wb.req_rd = '0; wb.req_data = '0;
        @(posedge clk); #1; chk_en = 1;
        tick;
        rst = 0;
        probe;
        chk("reset_rf_wr", 32'(rf_wr), 0);
        chk("reset_rf_rd_d", rf_rd_d, 0);
        chk("idle_ready", 32'(wb.req_ready), 0);
        tick;

        // all three valid: rotate 0,1,2,0,1,2
        wb.req_valid = 3'b111;
        wb.req_rd[0] = 5'd5; wb.req_rd[1] = 5'd6; wb.req_rd[2] = 5'd7;
        wb.req_data[0] = 32'hA; wb.req_data[1] = 32'hB; wb.req_data[2] = 32'hC;
        for (int c = 0; c < 6; c++) begin
            probe;
            chk("rr_grant", 32'(wb.req_ready), 32'(rr_exp[c]));
            if (c > 0) chk("rr_wr_rd", 32'(rf_rd), 32'(5 + (c - 1) % 3));
            tick;
        end
        wb.req_valid = '0;
        probe;
        chk("rr_last_wr", 32'(rf_wr), 1);
        chk("rr_last_data", rf_rd_d, 32'hC);
        tick;

        // single LSU request
        wb.req_valid = 3'b010; wb.req_rd[1] = 5'd9; wb.req_data[1] = 32'hDEADBEEF;
        probe; chk("single_grant", 32'(wb.req_ready), 32'b010);
        tick; wb.req_valid = '0;
        probe; chk("single_wr", 32'(rf_wr), 1); chk("single_rd", 32'(rf_rd), 9);
        chk("single_data", rf_rd_d, 32'hDEADBEEF);
        tick;
        probe; chk("single_idle_wr", 32'(rf_wr), 0);
        tick;

        // write to x0
        wb.req_valid = 3'b001; wb.req_rd[0] = 5'd0; wb.req_data[0] = 32'h1234;
        probe; chk("x0_grant", 32'(wb.req_ready), 32'b001);
        tick; wb.req_valid = '0;
        probe; chk("x0_no_wr", 32'(rf_wr), 0);
        tick;

        // scoreboard set / double issue / LSU clear
        issue_valid = 1; issue_rd = 5'd12;
        probe; chk("iss12_ready", 32'(issue_ready), 1);
        tick; ra = 5'd12;
        probe; chk("ra12_busy", 32'(ra_busy), 1); chk("iss12_again", 32'(issue_ready), 0);
        tick; issue_valid = 0;
        wb.req_valid = 3'b010; wb.req_rd[1] = 5'd12; wb.req_data[1] = 32'h55;
        probe; chk("lsu12_grant", 32'(wb.req_ready), 32'b010);
        tick; wb.req_valid = '0;
        probe; chk("ra12_inflight", 32'(ra_busy), 1);
        tick;
        probe; chk("ra12_free", 32'(ra_busy), 0);
        tick;

        // same-cycle LSU clear and issue of rd=4: set wins
        rb = 5'd4;
        wb.req_valid = 3'b010; wb.req_rd[1] = 5'd4; wb.req_data[1] = 32'h44;
        issue_valid = 1; issue_rd = 5'd4;
        probe; chk("iss4_ready", 32'(issue_ready), 1); chk("rb4_before", 32'(rb_busy), 0);
        tick; wb.req_valid = '0; issue_valid = 0;
        tick;
        probe; chk("rb4_still_pend", 32'(rb_busy), 1);
        tick;

        // flush with concurrent issue
        flush = 1; issue_valid = 1; issue_rd = 5'd8; ra = 5'd8;
        probe; chk("flush_iss_ready", 32'(issue_ready), 0);
        tick; flush = 0; issue_valid = 0;
        probe; chk("flush_ra8", 32'(ra_busy), 0); chk("flush_rb4", 32'(rb_busy), 0);
        tick;

        // reset while ALU and LSU request
        wb.req_valid = 3'b011; wb.req_rd[0] = 5'd3; wb.req_data[0] = 32'h33;
        wb.req_rd[1] = 5'd10; wb.req_data[1] = 32'hAA;
        tick;
        rst = 1;
        probe; chk("rst_ready", 32'(wb.req_ready), 0);
        tick; rst = 0;
        probe; chk("post_rst_wr", 32'(rf_wr), 0); chk("post_rst_grant", 32'(wb.req_ready), 32'b001);
        tick; wb.req_valid = '0;
        probe; chk("post_rst_rd", 32'(rf_rd), 3); chk("post_rst_data", rf_rd_d, 32'h33);
        tick; tick;

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
